// File: rtl/controle_multiciclo.sv
// Purpose : multicycle MIPS-subset control FSM (R-type, lw, sw, beq, j, addi) driving datapath muxes, strobes and ULA op.
// Latency : lw 5, sw/R/addi 4, beq/j 3 cycles incl. FETCH; all outputs registered, Moore on the state register.
// Backpressure: none; the FSM advances every cycle, memory is assumed single-cycle.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   opcode, funct     IR[31:26] / IR[5:0], sampled only on the DECODE edge
//   ula_op            0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1111 none
//   ula_src_a/_b      ULA operand selects (A: PC/regA; B: regB/4/imm/imm<<2)
//   pc_write(_cond), pc_source   PC load controls
//   i_or_d, mem_read, mem_write, ir_write   memory address select and strobes
//   reg_dst, mem_to_reg, reg_write          register-file write controls
//   state             current state encoding (debug)
//   illegal           one-cycle pulse after an unsupported opcode/funct
//   instr_count       completed-instruction counter (wraps)
module controle_multiciclo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [3:0]  ula_op,
    output logic        ula_src_a,
    output logic [1:0]  ula_src_b,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_source,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EX   = 4'd11,
        ADDI_WB   = 4'd12
    } state_t;

    typedef struct packed {
        logic [3:0] ula_op;
        logic       ula_src_a;
        logic [1:0] ula_src_b;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] ULA_ADD  = 4'b0010;
    localparam logic [3:0] ULA_SUB  = 4'b0110;
    localparam logic [3:0] ULA_AND  = 4'b0000;
    localparam logic [3:0] ULA_OR   = 4'b0001;
    localparam logic [3:0] ULA_SLT  = 4'b0111;
    localparam logic [3:0] ULA_NONE = 4'b1111;

    // R-type funct to ULA op; ULA_NONE doubles as the "unsupported funct" marker.
    function automatic logic [3:0] r_ula(input logic [5:0] f);
        case (f)
            6'b100000: r_ula = ULA_ADD;
            6'b100010: r_ula = ULA_SUB;
            6'b100100: r_ula = ULA_AND;
            6'b100101: r_ula = ULA_OR;
            6'b101010: r_ula = ULA_SLT;
            default:   r_ula = ULA_NONE;
        endcase
    endfunction

    // Moore output table for a state; f is the funct latched for that state.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c        = '0;
        c.ula_op = ULA_NONE;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.ula_src_b = 2'b01;
                c.ula_op    = ULA_ADD;
                c.pc_write  = 1'b1;
            end
            DECODE: begin
                c.ula_src_b = 2'b11;
                c.ula_op    = ULA_ADD;
            end
            MEM_ADDR, ADDI_EX: begin
                c.ula_src_a = 1'b1;
                c.ula_src_b = 2'b10;
                c.ula_op    = ULA_ADD;
            end
            MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            EXECUTE: begin
                c.ula_src_a = 1'b1;
                c.ula_op    = r_ula(f);
            end
            R_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.ula_src_a     = 1'b1;
                c.ula_op        = ULA_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            ADDI_WB: c.reg_write = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    state_t     st_q, st_nxt;
    logic [5:0] opcode_q, funct_q, funct_nxt;
    ctrl_t      ctrl_q;
    logic       ill_nxt;
    logic       done;

    // funct_nxt is the funct the next state will see, so EXECUTE's ula_op can
    // be registered on the same edge that latches funct.
    always_comb begin
        st_nxt    = st_q;
        ill_nxt   = 1'b0;
        funct_nxt = (st_q == DECODE) ? funct : funct_q;
        case (st_q)
            IDLE:   st_nxt = FETCH;
            FETCH:  st_nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:      st_nxt = EXECUTE;
                    OP_LW, OP_SW:  st_nxt = MEM_ADDR;
                    OP_BEQ:        st_nxt = BRANCH;
                    OP_J:          st_nxt = JUMP;
                    OP_ADDI:       st_nxt = ADDI_EX;
                    default: begin
                        st_nxt  = FETCH;
                        ill_nxt = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: st_nxt = (opcode_q == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ: st_nxt = MEM_WB;
            EXECUTE: begin
                if (r_ula(funct_q) != ULA_NONE) begin
                    st_nxt = R_WB;
                end else begin
                    st_nxt  = FETCH;
                    ill_nxt = 1'b1;
                end
            end
            ADDI_EX: st_nxt = ADDI_WB;
            default: st_nxt = FETCH;
        endcase
    end

    // Final state of every legal instruction; illegal exits never pass here.
    assign done = (st_q == MEM_WB) || (st_q == MEM_WRITE) || (st_q == R_WB) ||
                  (st_q == BRANCH) || (st_q == JUMP) || (st_q == ADDI_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= IDLE;
            opcode_q    <= '0;
            funct_q     <= '0;
            ctrl_q      <= ctrl_for(IDLE, 6'd0);
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            st_q    <= st_nxt;
            funct_q <= funct_nxt;
            if (st_q == DECODE) begin
                opcode_q <= opcode;
            end
            ctrl_q  <= ctrl_for(st_nxt, funct_nxt);
            illegal <= ill_nxt;
            if (done) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

    assign state         = st_q;
    assign ula_op        = ctrl_q.ula_op;
    assign ula_src_a     = ctrl_q.ula_src_a;
    assign ula_src_b     = ctrl_q.ula_src_b;
    assign pc_write      = ctrl_q.pc_write;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign pc_source     = ctrl_q.pc_source;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign ir_write      = ctrl_q.ir_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_write     = ctrl_q.reg_write;

endmodule
